// File: rtl/in_data_xbar_pkg.sv
// Shared types and constants for the input data crossbar:
// reconfiguration FSM states, blanking/settle phase lengths and the
// deepest per-lane delay.
package in_data_xbar_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BLANK  = 2'd1,
        ST_SETTLE = 2'd2
    } xbar_state_t;

    localparam int unsigned BLANK_CYC   = 2;
    localparam int unsigned SETTLE_CYC  = 4;
    localparam int unsigned MAX_DLY     = 3;
    localparam int unsigned PHASE_CNT_W = 3;

    // Terminal value of the phase counter for a phase lasting 'cycles' clocks
    function automatic logic [PHASE_CNT_W-1:0] lastPhaseCycle(input int unsigned cycles);
        return PHASE_CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/in_data_xbar_lane_cond.sv
// Per-lane input conditioning: samples the raw serial bit, applies the
// polarity invert, delays it by 0..3 extra cycles and flags toggles of the
// raw sample for activity monitoring.
module in_lane_cond
    import in_data_xbar_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       sin_i,
    input  logic       inv_i,
    input  logic [1:0] dly_i,
    output logic       dout_o,
    output logic       toggle_o
);

    logic               sample_q;
    logic               prevSample_q;
    logic               condBit;
    logic [MAX_DLY-1:0] dlyLine_q;
    logic [MAX_DLY-1:0] dlyLine_d;

    // Polarity correction is applied after the first register stage
    assign condBit   = sample_q ^ inv_i;
    assign dlyLine_d = {dlyLine_q[MAX_DLY-2:0], condBit};

    // Activity looks at the raw sample, so invert and delay never mask a toggle
    assign toggle_o  = sample_q ^ prevSample_q;

    // Input sample stage, previous-sample memory and the delay shift line
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sample_q     <= 1'b0;
            prevSample_q <= 1'b0;
            dlyLine_q    <= '0;
        end else begin
            sample_q     <= sin_i;
            prevSample_q <= sample_q;
            dlyLine_q    <= dlyLine_d;
        end
    end

    // Tap select: zero extra delay takes the conditioned sample directly
    always_comb begin
        dout_o = condBit;
        case (dly_i)
            2'd0:    dout_o = condBit;
            2'd1:    dout_o = dlyLine_q[0];
            2'd2:    dout_o = dlyLine_q[1];
            default: dout_o = dlyLine_q[2];
        endcase
    end

endmodule

// File: rtl/in_data_xbar.sv
// Input data crossbar: conditions N_IN serial lanes, routes any lane to
// each of N_OUT registered outputs, applies configuration changes through
// a shadow/active pair with a blank-then-settle window, and reports
// per-lane activity over a free-running window.
module in_data_xbar
    import in_data_xbar_pkg::*;
#(
    parameter int N_IN  = 9,
    parameter int N_OUT = 9,
    parameter int SEL_W = 4,
    parameter int WIN_W = 8
) (
    input  logic                   clk320,
    input  logic                   rst,
    input  logic [N_IN-1:0]        s_in,
    input  logic [N_OUT*SEL_W-1:0] sel_cfg,
    input  logic [2*N_IN-1:0]      dly_cfg,
    input  logic [N_IN-1:0]        inv_cfg,
    input  logic                   cfg_load,
    output logic [N_OUT-1:0]       s_out,
    output logic                   cfg_busy,
    output logic [N_IN-1:0]        act
);

    xbar_state_t              state_q;
    xbar_state_t              state_d;
    logic [PHASE_CNT_W-1:0]   phaseCnt_q;
    logic [PHASE_CNT_W-1:0]   phaseCnt_d;

    logic                     captureCfg;
    logic                     commitCfg;
    logic                     busy;
    logic                     blankOut;

    logic [N_OUT*SEL_W-1:0]   shadowSel_q;
    logic [2*N_IN-1:0]        shadowDly_q;
    logic [N_IN-1:0]          shadowInv_q;
    logic [N_OUT*SEL_W-1:0]   activeSel_q;
    logic [2*N_IN-1:0]        activeDly_q;
    logic [N_IN-1:0]          activeInv_q;

    logic [N_IN-1:0]          laneOut;
    logic [N_IN-1:0]          laneToggle;
    logic [N_OUT-1:0]         routed;
    logic [N_OUT-1:0]         sOut_q;
    logic [N_OUT-1:0]         sOut_d;

    logic [WIN_W-1:0]         win_q;
    logic                     winWrap;
    logic [N_IN-1:0]          sticky_q;
    logic [N_IN-1:0]          stickyAll;
    logic [N_IN-1:0]          act_q;

    // One conditioning slice per input lane, driven only by active settings
    for (genvar i = 0; i < N_IN; i++) begin : g_lane
        in_lane_cond u_lane (
            .clk_i    (clk320),
            .rst_ni   (rst),
            .sin_i    (s_in[i]),
            .inv_i    (activeInv_q[i]),
            .dly_i    (activeDly_q[2*i +: 2]),
            .dout_o   (laneOut[i]),
            .toggle_o (laneToggle[i])
        );
    end

    // FSM state register and phase counter
    always_ff @(posedge clk320 or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            phaseCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            phaseCnt_q <= phaseCnt_d;
        end
    end

    // FSM next state: any new load restarts blanking so the latest config wins
    always_comb begin
        state_d    = state_q;
        phaseCnt_d = phaseCnt_q;
        case (state_q)
            ST_IDLE: begin
                if (cfg_load) begin
                    state_d    = ST_BLANK;
                    phaseCnt_d = '0;
                end
            end
            ST_BLANK: begin
                if (cfg_load) begin
                    phaseCnt_d = '0;
                end else if (phaseCnt_q == lastPhaseCycle(BLANK_CYC)) begin
                    state_d    = ST_SETTLE;
                    phaseCnt_d = '0;
                end else begin
                    phaseCnt_d = phaseCnt_q + 1'b1;
                end
            end
            ST_SETTLE: begin
                if (cfg_load) begin
                    state_d    = ST_BLANK;
                    phaseCnt_d = '0;
                end else if (phaseCnt_q == lastPhaseCycle(SETTLE_CYC)) begin
                    state_d    = ST_IDLE;
                    phaseCnt_d = '0;
                end else begin
                    phaseCnt_d = phaseCnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                phaseCnt_d = '0;
            end
        endcase
    end

    // FSM outputs: blanking follows the next state so outputs drop in the first busy cycle
    always_comb begin
        captureCfg = cfg_load;
        commitCfg  = (state_q == ST_BLANK) && !cfg_load
                     && (phaseCnt_q == lastPhaseCycle(BLANK_CYC));
        busy       = (state_q != ST_IDLE);
        blankOut   = (state_d != ST_IDLE);
    end

    assign cfg_busy = busy;

    // Shadow captures on every load, active takes shadow on the last blank cycle
    always_ff @(posedge clk320 or negedge rst) begin
        if (!rst) begin
            shadowSel_q <= '0;
            shadowDly_q <= '0;
            shadowInv_q <= '0;
            activeSel_q <= '0;
            activeDly_q <= '0;
            activeInv_q <= '0;
        end else begin
            if (captureCfg) begin
                shadowSel_q <= sel_cfg;
                shadowDly_q <= dly_cfg;
                shadowInv_q <= inv_cfg;
            end
            if (commitCfg) begin
                activeSel_q <= shadowSel_q;
                activeDly_q <= shadowDly_q;
                activeInv_q <= shadowInv_q;
            end
        end
    end

    // Routing mux: out-of-range source indices select a constant zero
    always_comb begin
        routed = '0;
        for (int k = 0; k < N_OUT; k++) begin
            for (int j = 0; j < N_IN; j++) begin
                if (activeSel_q[k*SEL_W +: SEL_W] == SEL_W'(j)) begin
                    routed[k] = laneOut[j];
                end
            end
        end
        sOut_d = blankOut ? '0 : routed;
    end

    // Registered output lanes
    always_ff @(posedge clk320 or negedge rst) begin
        if (!rst) begin
            sOut_q <= '0;
        end else begin
            sOut_q <= sOut_d;
        end
    end

    assign s_out = sOut_q;

    assign winWrap   = (win_q == {WIN_W{1'b1}});
    assign stickyAll = sticky_q | laneToggle;

    // Activity window: toggles landing on the wrap cycle still count for the closing window
    always_ff @(posedge clk320 or negedge rst) begin
        if (!rst) begin
            win_q    <= '0;
            sticky_q <= '0;
            act_q    <= '0;
        end else begin
            win_q <= win_q + 1'b1;
            if (winWrap) begin
                act_q    <= stickyAll;
                sticky_q <= '0;
            end else begin
                sticky_q <= stickyAll;
            end
        end
    end

    assign act = act_q;

endmodule

// File: tb/tb_in_data_xbar.sv
// Directed self-checking bench for in_data_xbar (window shortened to 16 cycles).
module tb_in_data_xbar;

    localparam int N_IN  = 9;
    localparam int N_OUT = 9;
    localparam int SEL_W = 4;
    localparam int WIN_W = 4;

    logic                   clk320;
    logic                   rst;
    logic [N_IN-1:0]        s_in;
    logic [N_OUT*SEL_W-1:0] sel_cfg;
    logic [2*N_IN-1:0]      dly_cfg;
    logic [N_IN-1:0]        inv_cfg;
    logic                   cfg_load;
    logic [N_OUT-1:0]       s_out;
    logic                   cfg_busy;
    logic [N_IN-1:0]        act;

    int errors;
    int checks;

    logic [N_OUT*SEL_W-1:0] selCfgA;
    logic [2*N_IN-1:0]      dlyCfgA;
    logic [N_IN-1:0]        invCfgA;
    logic [N_OUT*SEL_W-1:0] selCfgB;
    logic [N_IN-1:0]        invCfgB;

    in_data_xbar #(
        .N_IN  (N_IN),
        .N_OUT (N_OUT),
        .SEL_W (SEL_W),
        .WIN_W (WIN_W)
    ) dut (
        .clk320   (clk320),
        .rst      (rst),
        .s_in     (s_in),
        .sel_cfg  (sel_cfg),
        .dly_cfg  (dly_cfg),
        .inv_cfg  (inv_cfg),
        .cfg_load (cfg_load),
        .s_out    (s_out),
        .cfg_busy (cfg_busy),
        .act      (act)
    );

    // 10 ns clock
    initial clk320 = 1'b0;
    always #5 clk320 = ~clk320;

    // Hard stop in case the sequence ever stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance one clock and settle just past the edge
    task automatic tick();
        @(posedge clk320);
        #1;
    endtask

    task automatic applyStimulus(input logic [N_IN-1:0]        sin,
                                 input logic [N_OUT*SEL_W-1:0] sel,
                                 input logic [2*N_IN-1:0]      dly,
                                 input logic [N_IN-1:0]        inv,
                                 input logic                   load);
        s_in     = sin;
        sel_cfg  = sel;
        dly_cfg  = dly;
        inv_cfg  = inv;
        cfg_load = load;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b0;
        applyStimulus('0, '0, '0, '0, 1'b0);

        // Reset state
        repeat (3) tick();
        checkOutput("reset_s_out", 32'(s_out), 32'h0);
        checkOutput("reset_busy", 32'(cfg_busy), 32'h0);
        checkOutput("reset_act", 32'(act), 32'h0);

        // Default routing: lane 0 to every output, two-cycle latency
        rst  = 1'b1;
        s_in = 9'h001;
        tick();
        checkOutput("pulse_lat1", 32'(s_out), 32'h0);
        s_in = 9'h000;
        tick();
        checkOutput("pulse_all", 32'(s_out), 32'h1FF);
        tick();
        checkOutput("pulse_end", 32'(s_out), 32'h0);

        // Out 3 <- lane 5 inverted with 3 extra cycles, out 2 <- lane 15 (none)
        selCfgA = '0;
        selCfgA[3*SEL_W +: SEL_W] = 4'd5;
        selCfgA[2*SEL_W +: SEL_W] = 4'd15;
        dlyCfgA = '0;
        dlyCfgA[2*5 +: 2] = 2'd3;
        invCfgA = '0;
        invCfgA[5] = 1'b1;
        applyStimulus('0, selCfgA, dlyCfgA, invCfgA, 1'b1);
        tick();
        applyStimulus('0, '1, '1, '1, 1'b0);
        checkOutput("cfgA_busy_1", 32'(cfg_busy), 32'h1);
        checkOutput("cfgA_blank_1", 32'(s_out), 32'h0);
        for (int c = 2; c <= 6; c++) begin
            tick();
            checkOutput($sformatf("cfgA_busy_%0d", c), 32'(cfg_busy), 32'h1);
            checkOutput($sformatf("cfgA_blank_%0d", c), 32'(s_out), 32'h0);
        end
        tick();
        checkOutput("cfgA_idle", 32'(cfg_busy), 32'h0);
        checkOutput("cfgA_steady", 32'(s_out), 32'h008);

        // All lanes high for one cycle; out 3 dips five cycles later, out 2 never moves
        s_in = 9'h1FF;
        tick();
        checkOutput("cfgA_t1", 32'(s_out), 32'h008);
        s_in = 9'h000;
        tick();
        checkOutput("cfgA_t2", 32'(s_out), 32'h1FB);
        tick();
        checkOutput("cfgA_t3", 32'(s_out), 32'h008);
        tick();
        checkOutput("cfgA_t4", 32'(s_out), 32'h008);
        tick();
        checkOutput("cfgA_t5", 32'(s_out), 32'h000);
        tick();
        checkOutput("cfgA_t6", 32'(s_out), 32'h008);

        // Second load three cycles after the first restarts blanking
        selCfgA = '0;
        selCfgA[0 +: SEL_W] = 4'd8;
        invCfgA = '0;
        invCfgA[8] = 1'b1;
        selCfgB = '0;
        selCfgB[1*SEL_W +: SEL_W] = 4'd4;
        invCfgB = '0;
        invCfgB[4] = 1'b1;
        applyStimulus('0, selCfgA, '0, invCfgA, 1'b1);
        for (int t = 1; t <= 10; t++) begin
            tick();
            checkOutput($sformatf("restart_busy_%0d", t), 32'(cfg_busy), 32'(t <= 9));
            if (t == 3) begin
                applyStimulus('0, selCfgB, '0, invCfgB, 1'b1);
            end else begin
                applyStimulus('0, '1, '1, '1, 1'b0);
            end
        end
        checkOutput("restart_route", 32'(s_out), 32'h002);

        // Reset in the middle of settling drops the pending change
        applyStimulus('0, {N_OUT{4'd3}}, '0, 9'h008, 1'b1);
        tick();
        applyStimulus('0, '0, '0, '0, 1'b0);
        repeat (3) tick();
        checkOutput("abort_pre_busy", 32'(cfg_busy), 32'h1);
        rst = 1'b0;
        #1;
        checkOutput("abort_s_out", 32'(s_out), 32'h0);
        checkOutput("abort_busy", 32'(cfg_busy), 32'h0);
        checkOutput("abort_act", 32'(act), 32'h0);
        tick();
        rst  = 1'b1;
        s_in = 9'h001;
        tick();
        s_in = 9'h000;
        tick();
        checkOutput("abort_lane0", 32'(s_out), 32'h1FF);
        s_in = 9'h008;
        tick();
        checkOutput("abort_lane0_end", 32'(s_out), 32'h0);
        s_in = 9'h000;
        tick();
        checkOutput("abort_lane3_ignored", 32'(s_out), 32'h0);
        checkOutput("abort_busy_after", 32'(cfg_busy), 32'h0);

        // Activity windows from a fresh reset (16-cycle window)
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        for (int k = 1; k <= 64; k++) begin
            tick();
            case (k)
                15: checkOutput("act_first_window", 32'(act), 32'h000);
                16: checkOutput("act_lane7", 32'(act), 32'h080);
                31: checkOutput("act_hold", 32'(act), 32'h080);
                32: checkOutput("act_quiet", 32'(act), 32'h000);
                47: checkOutput("act_pre_wrap", 32'(act), 32'h000);
                48: checkOutput("act_wrap_toggle", 32'(act), 32'h004);
                64: checkOutput("act_cleared", 32'(act), 32'h000);
                default: ;
            endcase
            case (k)
                1:  s_in[7] = 1'b1;
                3:  s_in[7] = 1'b0;
                5:  s_in[7] = 1'b1;
                6:  s_in[7] = 1'b0;
                46: s_in[2] = 1'b1;
                default: ;
            endcase
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/in_data_xbar.md
IN_DATA_XBAR -- requirements
Module: in_data_xbar

Interface
REQ-001 SHALL have parameter N_IN, default 9, number of serial input lanes.
REQ-002 SHALL have parameter N_OUT, default 9, number of routed output lanes.
REQ-003 SHALL have parameter SEL_W, default 4, select field width; SEL_W >= clog2(N_IN+1).
REQ-004 SHALL have parameter WIN_W, default 8, activity-window counter width.
REQ-005 SHALL have port clk320  input  1  sole clock, all flops rising-edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port s_in  input  N_IN  raw serial input lanes.
REQ-008 SHALL have port sel_cfg  input  N_OUT*SEL_W  per-output source index, field k at bits [k*SEL_W +: SEL_W].
REQ-009 SHALL have port dly_cfg  input  2*N_IN  per-input extra delay, 0..3 cycles.
REQ-010 SHALL have port inv_cfg  input  N_IN  per-input polarity invert.
REQ-011 SHALL have port cfg_load  input  1  single-cycle strobe capturing sel_cfg/dly_cfg/inv_cfg.
REQ-012 SHALL have port s_out  output  N_OUT  routed, registered output lanes.
REQ-013 SHALL have port cfg_busy  output  1  high while a configuration change is being applied.
REQ-014 SHALL have port act  output  N_IN  per-input activity flags from the last completed window.

Function
REQ-015 SHALL register s_in every cycle (stage 1), then apply inv_cfg XOR, then a per-input shift delay of dly_cfg cycles.
REQ-016 SHALL register s_out; latency from s_in to s_out = 2 + active delay cycles (2..5).
REQ-017 s_out[k] SHALL equal delayed lane j where j = active sel field k; any j >= N_IN drives 1'b0.
REQ-018 Configuration SHALL use shadow (captured at cfg_load) and active registers; datapath uses only active values.
REQ-019 SHALL implement FSM IDLE -> BLANK -> SETTLE -> IDLE.
REQ-020 IDLE: cfg_load=1 captures shadow, goes to BLANK next cycle, cfg_busy=1 from that cycle.
REQ-021 BLANK: s_out forced to 0 for exactly 2 cycles; active <= shadow on the last BLANK cycle; then SETTLE.
REQ-022 SETTLE: s_out stays 0 for 4 cycles so delay lines refill; then IDLE, cfg_busy=0, routing resumes.
REQ-023 cfg_load in BLANK or SETTLE SHALL recapture shadow and restart BLANK (latest config wins, no lost update).
REQ-024 Window counter WIN_W bits SHALL free-run and wrap 2^WIN_W-1 -> 0.
REQ-025 SHALL set a per-input sticky toggle bit when stage-1 sample differs from previous sample; at wrap, act <= sticky bits (including a toggle on the wrap cycle) and sticky clears.
REQ-026 Activity detection SHALL ignore inv_cfg/dly_cfg and continue during BLANK/SETTLE.

Reset
REQ-027 During rst=0: all pipeline, delay, shadow and active registers 0; FSM IDLE; window counter 0.
REQ-028 Reset outputs: s_out=0, cfg_busy=0, act=0; active sel fields 0 (all outputs route lane 0 after reset).
REQ-029 Reset asserted mid-BLANK/SETTLE SHALL abort the change; pending shadow discarded.
REQ-030 Reset deassertion needs no cfg_load; routing active 2 cycles after first clock edge.

Structure
REQ-031 Shared package SHALL hold FSM state enum, BLANK_CYC=2, SETTLE_CYC=4, MAX_DLY=3.
REQ-032 One sub-module in_lane_cond (sample, invert, 0..3 delay, toggle detect), instantiated N_IN times via generate.
REQ-033 Routing mux and FSM SHALL stay in in_data_xbar.

Verification
REQ-034 Reset, default config, s_in[0] pulse -> pulse on every s_out bit after 2 cycles.
REQ-035 sel field 3 = 5, dly_cfg lane 5 = 3, inv lane 5 = 1, cfg_load -> cfg_busy 6 cycles, then s_out[3] = ~s_in[5] delayed 5 cycles.
REQ-036 sel field 2 = 15 (>= N_IN) -> s_out[2] stays 0 for any s_in.
REQ-037 Second cfg_load 3 cycles after first -> BLANK restarts, second config applied, cfg_busy total 9 cycles.
REQ-038 WIN_W=4, toggle only s_in[7] -> after wrap at cycle 15, act = 9'h080; next window quiet -> act = 0.
REQ-039 rst low during SETTLE -> s_out=0, cfg_busy=0, routing = lane 0 after release.
